// File: rtl/dp_instr_encoder_pkg.sv
// dp_instr_encoder_pkg: shared codes, field layout and helpers for the ARM data-processing encoder
package dp_instr_encoder_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;
  localparam logic [1:0] OP2_IMM = 2'd0;
  localparam logic [1:0] OP2_REG_IMM = 2'd1;
  localparam logic [1:0] OP2_REG_REG = 2'd2;
  localparam logic [1:0] OP2_ILL = 2'd3;
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;
  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam int COND_LSB = 28;
  localparam int I_BIT = 25;
  localparam int OPC_LSB = 21;
  localparam int S_BIT = 20;
  localparam int RN_LSB = 16;
  localparam int RD_LSB = 12;
  // Upper 20 bits of the word: cond, 00, I, opcode, S, Rn, Rd
  function automatic logic [19:0] mk_hdr(input logic [3:0] c, input logic [3:0] op,
                                         input logic s_bit, input logic [3:0] n,
                                         input logic [3:0] d, input logic i);
    return {c, 2'b00, i, op, s_bit, n, d};
  endfunction
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] d;
    d = {v, v} << {r, 1'b0};
    return d[63:32];
  endfunction
endpackage

// File: rtl/imm_rot_matcher.sv
// imm_rot_matcher: tests N consecutive rotate candidates, reports the lowest one whose value fits in 8 bits
module imm_rot_matcher
  import dp_instr_encoder_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [31:0] value,
  input  logic [3:0]  base_rot,
  output logic        hit,
  output logic [3:0]  rot,
  output logic [7:0]  imm8
);
  logic [31:0] rv;
  always_comb begin
    hit = 1'b0;
    rot = '0;
    imm8 = '0;
    rv = '0;
    for (int i = N - 1; i >= 0; i--) begin
      rv = rol2(value, base_rot + 4'(i));
      if (rv[31:8] == 24'd0) begin
        hit = 1'b1;
        rot = base_rot + 4'(i);
        imm8 = rv[7:0];
      end
    end
  end
endmodule

// File: rtl/dp_instr_encoder.sv
// dp_instr_encoder: builds ARM data-processing words; immediates are encoded by a multi-cycle rotate search
module dp_instr_encoder
  import dp_instr_encoder_pkg::*;
#(
  parameter int ROTS_PER_CYCLE = 1
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [1:0]  op2_mode,
  input  logic [31:0] imm_value,
  input  logic [3:0]  rm,
  input  logic [3:0]  rs,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic        err
);
  localparam logic [3:0] STEP = 4'(ROTS_PER_CYCLE);
  localparam logic [3:0] LAST = 4'(ROTS_PER_CYCLE - 1);
  state_t state, state_d;
  logic [3:0] rot, rot_d, hit_rot;
  logic [19:0] hdr, hdr_d;
  logic [31:0] imm_q, imm_d, instr_d;
  logic [7:0] hit_imm8;
  logic err_d, hit;
  imm_rot_matcher #(.N(ROTS_PER_CYCLE)) u_imm_rot_matcher (
    .value(imm_q), .base_rot(rot), .hit(hit), .rot(hit_rot), .imm8(hit_imm8)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  always_comb begin
    state_d = state;
    rot_d = rot;
    hdr_d = hdr;
    imm_d = imm_q;
    instr_d = instruction;
    err_d = err;
    case (state)
      IDLE: if (in_valid) begin
        hdr_d = mk_hdr(cond, opcode, s, rn, rd, op2_mode == OP2_IMM);
        imm_d = imm_value;
        rot_d = '0;
        state_d = op2_mode == OP2_IMM ? SEARCH : OUT;
        err_d = op2_mode == OP2_ILL;
        instr_d = op2_mode == OP2_REG_IMM ? {hdr_d, shift_amt, shift_type, 1'b0, rm} :
                  op2_mode == OP2_REG_REG ? {hdr_d, rs, 1'b0, shift_type, 1'b1, rm} : '0;
      end
      SEARCH: begin
        rot_d = rot + STEP;
        if (hit) begin
          state_d = OUT;
          err_d = 1'b0;
          instr_d = {hdr, hit_rot, hit_imm8};
        end else if (rot + LAST == 4'd15) begin
          state_d = OUT;
          err_d = 1'b1;
          instr_d = '0;
        end
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rot <= '0;
      hdr <= '0;
      imm_q <= '0;
      instruction <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      rot <= rot_d;
      hdr <= hdr_d;
      imm_q <= imm_d;
      instruction <= instr_d;
      err <= err_d;
    end
  end
endmodule
